// File: rtl/mem_access_unit_if.sv
// rtl/mem_access_unit_if.sv - data-memory req/ack bus between the load/store unit and memory
interface mem_access_unit_if;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [3:0]  bus_wstrb;
  logic        bus_ack;
  logic [31:0] bus_rdata;

  modport master (
    output bus_req, bus_we, bus_addr, bus_wdata, bus_wstrb,
    input  bus_ack, bus_rdata
  );

  modport slave (
    input  bus_req, bus_we, bus_addr, bus_wdata, bus_wstrb,
    output bus_ack, bus_rdata
  );
endinterface

// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - load/store unit: validates, runs one bus transaction, formats load data
module mem_access_unit #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      mem_read,
  input  logic                      mem_write,
  input  logic [2:0]                funct3,
  input  logic [31:0]               ALU_out,
  input  logic [31:0]               Data_out,
  output logic [31:0]               Data_in,
  output logic                      stall,
  output logic                      fault,
  mem_access_unit_if.master         bus
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  localparam logic [7:0] LAST_CNT = 8'(TIMEOUT - 1);

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        bus_req_q, bus_req_d;
  logic        bus_we_q, bus_we_d;
  logic [31:0] bus_addr_q, bus_addr_d;
  logic [31:0] bus_wdata_q, bus_wdata_d;
  logic [3:0]  bus_wstrb_q, bus_wstrb_d;
  logic [2:0]  funct3_q, funct3_d;
  logic [1:0]  addr_lo_q, addr_lo_d;
  logic [31:0] data_in_q, data_in_d;
  logic        fault_q, fault_d;

  logic        access;
  logic        legal;
  logic [31:0] lane_wdata;
  logic [3:0]  lane_wstrb;
  logic [31:0] rd_byte_sh;
  logic [31:0] rd_half_sh;
  logic [31:0] load_fmt;

  assign access = mem_read | mem_write;

  always_comb begin
    legal = !(mem_read && mem_write);
    case (funct3)
      3'b000, 3'b001, 3'b010: ;
      3'b100, 3'b101: if (mem_write) legal = 1'b0;
      default: legal = 1'b0;
    endcase
    if (funct3[1:0] == 2'b01 && ALU_out[0]) legal = 1'b0;
    if (funct3[1:0] == 2'b10 && ALU_out[1:0] != 2'b00) legal = 1'b0;
  end

  // Stores replicate the narrow datum on every lane; the strobes select the target lane.
  always_comb begin
    case (funct3[1:0])
      2'b00: begin
        lane_wdata = {4{Data_out[7:0]}};
        lane_wstrb = 4'b0001 << ALU_out[1:0];
      end
      2'b01: begin
        lane_wdata = {2{Data_out[15:0]}};
        lane_wstrb = ALU_out[1] ? 4'b1100 : 4'b0011;
      end
      default: begin
        lane_wdata = Data_out;
        lane_wstrb = 4'b1111;
      end
    endcase
  end

  always_comb begin
    rd_byte_sh = bus.bus_rdata >> {addr_lo_q, 3'b000};
    rd_half_sh = bus.bus_rdata >> {addr_lo_q[1], 4'b0000};
    case (funct3_q)
      3'b000:  load_fmt = {{24{rd_byte_sh[7]}}, rd_byte_sh[7:0]};
      3'b001:  load_fmt = {{16{rd_half_sh[15]}}, rd_half_sh[15:0]};
      3'b100:  load_fmt = {24'd0, rd_byte_sh[7:0]};
      3'b101:  load_fmt = {16'd0, rd_half_sh[15:0]};
      default: load_fmt = bus.bus_rdata;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    bus_req_d   = bus_req_q;
    bus_we_d    = bus_we_q;
    bus_addr_d  = bus_addr_q;
    bus_wdata_d = bus_wdata_q;
    bus_wstrb_d = bus_wstrb_q;
    funct3_d    = funct3_q;
    addr_lo_d   = addr_lo_q;
    data_in_d   = data_in_q;
    fault_d     = fault_q;
    case (state_q)
      IDLE: begin
        if (access) begin
          if (legal) begin
            state_d     = BUSY;
            cnt_d       = 8'd0;
            bus_req_d   = 1'b1;
            bus_we_d    = mem_write;
            bus_addr_d  = {ALU_out[31:2], 2'b00};
            bus_wdata_d = mem_write ? lane_wdata : 32'd0;
            bus_wstrb_d = mem_write ? lane_wstrb : 4'd0;
            funct3_d    = funct3;
            addr_lo_d   = ALU_out[1:0];
          end else begin
            state_d   = DONE;
            fault_d   = 1'b1;
            data_in_d = 32'd0;
          end
        end
      end
      BUSY: begin
        // An ack arriving on the timeout cycle still completes the access cleanly.
        if (bus.bus_ack) begin
          state_d   = DONE;
          bus_req_d = 1'b0;
          cnt_d     = 8'd0;
          fault_d   = 1'b0;
          data_in_d = bus_we_q ? 32'd0 : load_fmt;
        end else if (cnt_q == LAST_CNT) begin
          state_d   = DONE;
          bus_req_d = 1'b0;
          cnt_d     = 8'd0;
          fault_d   = 1'b1;
          data_in_d = 32'd0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      DONE: begin
        state_d = IDLE;
        fault_d = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= 8'd0;
      bus_req_q   <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= 32'd0;
      bus_wdata_q <= 32'd0;
      bus_wstrb_q <= 4'd0;
      funct3_q    <= 3'd0;
      addr_lo_q   <= 2'd0;
      data_in_q   <= 32'd0;
      fault_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bus_req_q   <= bus_req_d;
      bus_we_q    <= bus_we_d;
      bus_addr_q  <= bus_addr_d;
      bus_wdata_q <= bus_wdata_d;
      bus_wstrb_q <= bus_wstrb_d;
      funct3_q    <= funct3_d;
      addr_lo_q   <= addr_lo_d;
      data_in_q   <= data_in_d;
      fault_q     <= fault_d;
    end
  end

  assign stall         = !rst && ((state_q == IDLE && access) || state_q == BUSY);
  assign fault         = fault_q;
  assign Data_in       = data_in_q;
  assign bus.bus_req   = bus_req_q;
  assign bus.bus_we    = bus_we_q;
  assign bus.bus_addr  = bus_addr_q;
  assign bus.bus_wdata = bus_wdata_q;
  assign bus.bus_wstrb = bus_wstrb_q;

endmodule
